// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory protocol types: word, RAM handshake state and arbiter FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DGRANT = 2'b01,
    IGRANT = 2'b10
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Picks the first asserted request at or after ptr (wrapping); returns its index and a valid flag.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          valid
);

  logic [2*N-1:0] dbl_s;
  logic [N-1:0]   rot_s;
  logic [IW:0]    sum_s;

  // Rotate so that bit 0 of rot_s is the requester the pointer names.
  assign dbl_s = {req, req} >> ptr;
  assign rot_s = dbl_s[N-1:0];
  assign valid = |req;

  // Lowest rotated offset wins; map it back to an absolute index modulo N.
  always_comb begin
    sum_s = {1'b0, ptr};
    for (int i = N - 1; i >= 0; i--) begin
      sum_s = rot_s[i] ? ({1'b0, ptr} + (IW+1)'(i)) : sum_s;
    end
    gnt_idx = (sum_s >= (IW+1)'(N)) ? (sum_s[IW-1:0] - IW'(N)) : sum_s[IW-1:0];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serializes icache/dcache word requests from all CPUs onto one RAM port, dcache first.
// Define MEM_ARB_RR_EN for round-robin among CPUs; otherwise lowest CPU index wins.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [CPUS-1:0]  iREN,
  input  logic [CPUS*32-1:0] iaddr,
  output logic [CPUS-1:0]  iwait,
  output logic [CPUS*32-1:0] iload,
  input  logic [CPUS-1:0]  dREN,
  input  logic [CPUS-1:0]  dWEN,
  input  logic [CPUS*32-1:0] daddr,
  input  logic [CPUS*32-1:0] dstore,
  output logic [CPUS-1:0]  dwait,
  output logic [CPUS*32-1:0] dload,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic [1:0]       ramstate
);

  localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;

  arb_state_t    state_r;
  logic [IW-1:0] gnt_r;
  logic          burst_r;
  logic [28:0]   burst_tag_r;

  logic [CPUS-1:0] d_req_s;
  logic [IW-1:0]   d_pick_s, i_pick_s, drr_ptr_s, irr_ptr_s, gnt_next_s;
  logic            d_any_s, i_any_s;
  word_t           cur_daddr_s, cur_dstore_s, cur_iaddr_s;
  logic            lock_ok_s, d_done_s, i_done_s, rearb_s;

`ifdef MEM_ARB_RR_EN
  logic [IW-1:0] drr_ptr_r, irr_ptr_r;
  assign drr_ptr_s = drr_ptr_r;
  assign irr_ptr_s = irr_ptr_r;
`else
  assign drr_ptr_s = {IW{1'b0}};
  assign irr_ptr_s = {IW{1'b0}};
`endif

  assign d_req_s      = dREN | dWEN;
  assign cur_daddr_s  = daddr[{gnt_r, 5'd0} +: 32];
  assign cur_dstore_s = dstore[{gnt_r, 5'd0} +: 32];
  assign cur_iaddr_s  = iaddr[{gnt_r, 5'd0} +: 32];
  assign gnt_next_s   = (gnt_r == IW'(CPUS - 1)) ? {IW{1'b0}} : (gnt_r + IW'(1'b1));
  assign iload        = {CPUS{ramload}};
  assign dload        = {CPUS{ramload}};

  // While a burst is pending, only the upper word of the same block keeps the lock.
  assign lock_ok_s = !burst_r ||
                     (d_req_s[gnt_r] && (cur_daddr_s[31:3] == burst_tag_r) && cur_daddr_s[2]);
  assign d_done_s  = (state_r == DGRANT) && d_req_s[gnt_r] && lock_ok_s && (ramstate == ACCESS);
  assign i_done_s  = (state_r == IGRANT) && iREN[gnt_r] && (ramstate == ACCESS);
  // A failed burst check behaves like an IDLE cycle so it costs no extra bubble.
  assign rearb_s   = (state_r == IDLE) || ((state_r == DGRANT) && !lock_ok_s);

  rr_picker #(.N(CPUS), .IW(IW)) u_dpick (
    .req(d_req_s), .ptr(drr_ptr_s), .gnt_idx(d_pick_s), .valid(d_any_s)
  );

  rr_picker #(.N(CPUS), .IW(IW)) u_ipick (
    .req(iREN), .ptr(irr_ptr_s), .gnt_idx(i_pick_s), .valid(i_any_s)
  );

  // RAM drive and per-requester wait, decoded from the registered grant.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'h0000_0000;
    ramstore = 32'h0000_0000;
    iwait    = {CPUS{1'b1}};
    dwait    = {CPUS{1'b1}};
    case (state_r)
      DGRANT: begin
        ramaddr  = cur_daddr_s;
        ramstore = cur_dstore_s;
        ramWEN   = lock_ok_s & dWEN[gnt_r];
        ramREN   = lock_ok_s & dREN[gnt_r] & ~dWEN[gnt_r];
        if (d_done_s) dwait[gnt_r] = 1'b0;
        else          dwait[gnt_r] = 1'b1;
      end
      IGRANT: begin
        ramaddr = cur_iaddr_s;
        ramREN  = iREN[gnt_r];
        if (i_done_s) iwait[gnt_r] = 1'b0;
        else          iwait[gnt_r] = 1'b1;
      end
      default: begin
        ramREN = 1'b0;
      end
    endcase
  end

  // Arbitration FSM with burst lock and round-robin pointers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r     <= IDLE;
      gnt_r       <= {IW{1'b0}};
      burst_r     <= 1'b0;
      burst_tag_r <= 29'h0;
`ifdef MEM_ARB_RR_EN
      drr_ptr_r   <= {IW{1'b0}};
      irr_ptr_r   <= {IW{1'b0}};
`endif
    end else begin
`ifdef MEM_ARB_RR_EN
      if (d_done_s) drr_ptr_r <= gnt_next_s;
      else          drr_ptr_r <= drr_ptr_r;
      if (i_done_s) irr_ptr_r <= gnt_next_s;
      else          irr_ptr_r <= irr_ptr_r;
`endif
      if (rearb_s) begin
        burst_r <= 1'b0;
        if (d_any_s) begin
          state_r <= DGRANT;
          gnt_r   <= d_pick_s;
        end else if (i_any_s) begin
          state_r <= IGRANT;
          gnt_r   <= i_pick_s;
        end else begin
          state_r <= IDLE;
        end
      end else begin
        case (state_r)
          DGRANT: begin
            if (!d_req_s[gnt_r]) begin
              state_r <= IDLE;
              burst_r <= 1'b0;
            end else if (d_done_s) begin
              if (!burst_r && !cur_daddr_s[2]) begin
                burst_r     <= 1'b1;
                burst_tag_r <= cur_daddr_s[31:3];
              end else begin
                burst_r <= 1'b0;
                state_r <= IDLE;
              end
            end else begin
              state_r <= DGRANT;
            end
          end
          IGRANT: begin
            if (!iREN[gnt_r] || i_done_s) state_r <= IDLE;
            else                          state_r <= IGRANT;
          end
          default: state_r <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a zero-latency RAM model that can be held BUSY.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int CPUS = 2;

  logic              CLK, nRST;
  logic [CPUS-1:0]   iREN, iwait, dREN, dWEN, dwait;
  logic [CPUS*32-1:0] iaddr, iload, daddr, dstore, dload;
  logic              ramREN, ramWEN;
  logic [31:0]       ramaddr, ramstore, ramload;
  logic [1:0]        ramstate;
  logic              hold_busy;
  int                checks, errors;

  mem_arbiter #(.CPUS(CPUS)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  assign ramstate = ((ramREN || ramWEN) && !hold_busy) ? ACCESS : (hold_busy ? BUSY : FREE);
  assign ramload  = (ramstate == ACCESS) ? (ramaddr ^ 32'hA5A5_0000) : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  initial begin
    CLK = 1'b0; nRST = 1'b0; hold_busy = 1'b0;
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    checks = 0; errors = 0;

    #2;
    chk("rst_iwait", 32'(iwait), 32'h3);
    chk("rst_dwait", 32'(dwait), 32'h3);
    chk("rst_ramREN", 32'(ramREN), 32'h0);
    chk("rst_ramWEN", 32'(ramWEN), 32'h0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_ramstore", ramstore, 32'h0);
    tick();
    nRST = 1'b1;

    // single dcache read, single-cycle RAM
    dREN = 2'b01; daddr[31:0] = 32'h100;
    smp(); chk("t1_arb_dwait", 32'(dwait), 32'h3); chk("t1_arb_ren", 32'(ramREN), 32'h0);
    tick();
    smp();
    chk("t1_ren", 32'(ramREN), 32'h1);
    chk("t1_addr", ramaddr, 32'h100);
    chk("t1_dwait", 32'(dwait), 32'h2);
    chk("t1_dload", dload[31:0], 32'hA5A5_0100);
    chk("t1_iload1", iload[63:32], 32'hA5A5_0100);
    tick(); dREN = 2'b00;
    smp(); chk("t1_after_ren", 32'(ramREN), 32'h0); chk("t1_after_dwait", 32'(dwait), 32'h3);
    tick();

    // dcache beats icache; icache served two cycles later
    dREN = 2'b01; daddr[31:0] = 32'h100; iREN = 2'b10; iaddr[63:32] = 32'h40;
    tick();
    smp(); chk("t2_dwait", 32'(dwait), 32'h2); chk("t2_iwait_hold", 32'(iwait), 32'h3);
    tick(); dREN = 2'b00;
    smp(); chk("t2_gap_ren", 32'(ramREN), 32'h0); chk("t2_gap_iwait", 32'(iwait), 32'h3);
    tick();
    smp();
    chk("t2_iwait", 32'(iwait), 32'h1);
    chk("t2_iaddr", ramaddr, 32'h40);
    chk("t2_iload", iload[63:32], 32'hA5A5_0040);
    tick(); iREN = 2'b00;
    tick();

    // both dcaches continuously requesting; drr_ptr is 1 after the CPU0 completions above
    dREN = 2'b11; daddr = {32'h204, 32'h104};
    for (int k = 0; k < 4; k++) begin
      smp(); chk("t3_idle_dwait", 32'(dwait), 32'h3);
      tick();
      smp();
`ifdef MEM_ARB_RR_EN
      chk("t3_rr_dwait", 32'(dwait), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("t3_rr_addr", ramaddr, (k % 2 == 0) ? 32'h204 : 32'h104);
`else
      chk("t3_fp_dwait", 32'(dwait), 32'h2);
      chk("t3_fp_addr", ramaddr, 32'h104);
`endif
      tick();
    end
    dREN = 2'b00;
    tick();

    // CPU1 two-word writeback stays locked while CPU0 waits
    dWEN = 2'b10; daddr[63:32] = 32'h208; dstore[63:32] = 32'hDEAD_0001;
    smp(); chk("t4_arb_dwait", 32'(dwait), 32'h3);
    tick(); dREN = 2'b01; daddr[31:0] = 32'h104;
    smp();
    chk("t4_w0_wen", 32'(ramWEN), 32'h1);
    chk("t4_w0_ren", 32'(ramREN), 32'h0);
    chk("t4_w0_addr", ramaddr, 32'h208);
    chk("t4_w0_data", ramstore, 32'hDEAD_0001);
    chk("t4_w0_dwait", 32'(dwait), 32'h1);
    tick(); daddr[63:32] = 32'h20C; dstore[63:32] = 32'hDEAD_0002;
    smp();
    chk("t4_w1_wen", 32'(ramWEN), 32'h1);
    chk("t4_w1_addr", ramaddr, 32'h20C);
    chk("t4_w1_data", ramstore, 32'hDEAD_0002);
    chk("t4_w1_dwait", 32'(dwait), 32'h1);
    tick(); dWEN = 2'b00;
    smp(); chk("t4_idle_wen", 32'(ramWEN), 32'h0); chk("t4_idle_dwait", 32'(dwait), 32'h3);
    tick();
    smp(); chk("t4_cpu0_dwait", 32'(dwait), 32'h2); chk("t4_cpu0_addr", ramaddr, 32'h104);
    tick(); dREN = 2'b00;
    tick();

    // RAM BUSY for three grant cycles, ACCESS on the fourth
    hold_busy = 1'b1; dREN = 2'b01; daddr[31:0] = 32'h114;
    tick();
    for (int b = 0; b < 3; b++) begin
      smp(); chk("t5_busy_ren", 32'(ramREN), 32'h1); chk("t5_busy_dwait", 32'(dwait), 32'h3);
      tick();
    end
    hold_busy = 1'b0;
    smp(); chk("t5_dwait", 32'(dwait), 32'h2); chk("t5_dload", dload[31:0], 32'hA5A5_0114);
    tick(); dREN = 2'b00;
    tick();

    // icache drops its request before ACCESS
    hold_busy = 1'b1; iREN = 2'b01; iaddr[31:0] = 32'h80;
    tick();
    smp(); chk("t6_ren", 32'(ramREN), 32'h1); chk("t6_addr", ramaddr, 32'h80);
    tick(); iREN = 2'b00; hold_busy = 1'b0;
    smp(); chk("t6_drop_ren", 32'(ramREN), 32'h0); chk("t6_drop_iwait", 32'(iwait), 32'h3);
    tick();

    // reset asserted mid-grant drops RAM enables at once
    hold_busy = 1'b1; dREN = 2'b10; daddr[63:32] = 32'h304;
    tick();
    smp(); chk("t7_ren", 32'(ramREN), 32'h1);
    #1 nRST = 1'b0;
    #1;
    chk("t7_rst_ren", 32'(ramREN), 32'h0);
    chk("t7_rst_addr", ramaddr, 32'h0);
    chk("t7_rst_dwait", 32'(dwait), 32'h3);
    tick(); dREN = 2'b00; nRST = 1'b1; hold_busy = 1'b0;
    smp(); chk("t7_post_ren", 32'(ramREN), 32'h0); chk("t7_post_dwait", 32'(dwait), 32'h3);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Memory-side responder for the cache/control protocol: accepts word read/write requests from every CPU's icache and dcache, serializes them onto the single-port RAM, and returns per-requester wait/data. It terminates the request/`wait` handshake that the caches drive; caches issue, this block grants and completes. A dcache two-word block fill or writeback is kept atomic via a burst lock.

## Interface
Parameters:
- CPUS, 2, number of CPUs; one icache and one dcache requester each.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  CPUS  icache read request, per CPU.
- iaddr  in  CPUS x 32  icache word address.
- iwait  out  CPUS  icache stall; low exactly in the completion cycle.
- iload  out  CPUS x 32  icache read data; equals ramload for every CPU.
- dREN  in  CPUS  dcache read request.
- dWEN  in  CPUS  dcache write request.
- daddr  in  CPUS x 32  dcache word address.
- dstore  in  CPUS x 32  dcache write data.
- dwait  out  CPUS  dcache stall; low exactly in the completion cycle.
- dload  out  CPUS x 32  dcache read data; equals ramload for every CPU.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data, valid when ramstate = ACCESS.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.

## Operation
- States: IDLE, DGRANT, IGRANT. Registers: state, gnt_cpu (log2 CPUS bits), drr_ptr, irr_ptr, burst.
- IDLE: drives no RAM enables, all waits high. If any dREN|dWEN asserted, pick a dcache by round-robin from drr_ptr → DGRANT. Else if any iREN, pick icache from irr_ptr → IGRANT. Else stay.
- DGRANT: ramaddr = daddr[gnt], ramstore = dstore[gnt]; ramWEN = dWEN[gnt]; ramREN = dREN[gnt] & ~dWEN[gnt] (write wins if both). When ramstate = ACCESS: dwait[gnt] = 0, drr_ptr ← gnt+1 mod CPUS.
- IGRANT: ramaddr = iaddr[gnt], ramREN = iREN[gnt], ramWEN = 0; on ACCESS iwait[gnt] = 0, irr_ptr ← gnt+1 mod CPUS.
- Exit after ACCESS: → IDLE, except burst lock: DGRANT completion with daddr[gnt][2] = 0 sets burst; next cycle, if same dcache still requests with daddr[31:3] unchanged and bit 2 = 1, remain in DGRANT (no re-arbitration); otherwise → IDLE. burst clears on second completion or on exit.
- Granted requester drops its request before ACCESS: RAM enables drop same cycle (combinational), → IDLE next edge, no wait-low pulse, pointer unchanged.
- ramstate BUSY, FREE, ERROR in a grant state: hold, waits stay high.
- Ungranted requesters always see wait high. iload/dload are pure pass-through of ramload.

## Timing
- Reset (async): state IDLE, gnt_cpu 0, pointers 0, burst 0; hence all iwait/dwait 1, ramREN/ramWEN 0, ramaddr 0, ramstore 0.
- Latency from request assert (IDLE) to wait-low = 1 arbitration cycle + RAM latency (cycles in grant state until ACCESS, min 1). Single-cycle RAM: wait low in 2nd cycle.
- Locked second burst word: no IDLE bubble; wait-low one RAM latency after first word's completion.
- Wait-low is one cycle; requester must change address or drop request next cycle.
- Reset mid-grant: RAM enables drop asynchronously with nRST.

## Configuration
- MEM_ARB_RR_EN defined: round-robin among CPUs as above. Undefined: fixed priority, lowest CPU index wins; pointers not implemented. dcache-over-icache priority and burst lock unaffected.

## Structure
- cpu_types_pkg: word_t, ramstate_t (existing); add arb_state_t {IDLE, DGRANT, IGRANT}.
- Sub-module rr_picker (request vector + pointer → one-hot/index grant, valid); instanced once for dcaches, once for icaches.

## Test plan
- CPUS=2, single-cycle RAM, dREN[0] @0x100 only → ramREN high @0x100 in cycle 2, dwait[0] low cycle 2, dload[0] = ramload.
- dREN[0] @0x100 and iREN[1] @0x40 same cycle → dcache served first; icache granted after, iwait[1] low 2 cycles after dwait[0].
- dREN[0] and dREN[1] continuously, RR enabled → grants alternate 0,1,0,1; with macro off CPU0 always wins.
- dWEN[1] block writeback @0x208 then 0x20C while dREN[0] pending → 0x20C completes back-to-back, no IDLE cycle, before CPU0.
- RAM holds BUSY 3 cycles then ACCESS → dwait low only in 4th grant cycle; nRST asserted during BUSY → ramREN 0 immediately, state IDLE.
